// File: rtl/board_gpio_ctrl.sv
// Board GPIO front-end: synchronises and debounces buttons and switches, emits
// edge pulses, and drives the LED bank from a selectable source.
module board_gpio_ctrl #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned SW_W            = 8,
    parameter int unsigned LED_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HB_HALF_PERIOD  = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [SW_W-1:0]    sw_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [SW_W-1:0]    sw_state,
    output logic               sw_change,
    input  logic [1:0]         led_mode,
    input  logic [LED_W-1:0]   led_host,
    output logic [LED_W-1:0]   led_out
);

    localparam int unsigned IN_W   = NUM_BTN + SW_W;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HB_W   = $clog2(HB_HALF_PERIOD + 1);
    localparam int unsigned MAX_BS = (NUM_BTN > SW_W) ? NUM_BTN : SW_W;
    localparam int unsigned EXT_W  = (MAX_BS > LED_W) ? MAX_BS : LED_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_HALF_PERIOD - 1);

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_HOST = 2'd1;
    localparam logic [1:0] MODE_SW   = 2'd2;
    localparam logic [1:0] MODE_STAT = 2'd3;

    // Buttons occupy the low bits, switches the high bits of one input vector.
    logic [IN_W-1:0]  raw;
    logic [IN_W-1:0]  s1;
    logic [IN_W-1:0]  s2;
    logic [IN_W-1:0]  stable;
    logic [IN_W-1:0]  accept_c;
    logic [CNT_W-1:0] cnt [IN_W];

    logic [HB_W-1:0]  hb_cnt;
    logic             hb;

    logic [EXT_W-1:0] btn_ext_c;
    logic [EXT_W-1:0] sw_ext_c;
    logic [LED_W-1:0] led_c;

    assign raw       = {sw_in, btn_in};
    assign btn_state = stable[NUM_BTN-1:0];
    assign sw_state  = stable[IN_W-1:NUM_BTN];

    // A bit is accepted on the sample that completes a full mismatching run.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            accept_c[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            stable      <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            sw_change   <= 1'b0;
            for (int i = 0; i < int'(IN_W); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= raw;
            s2          <= s1;
            stable      <= stable ^ accept_c;
            btn_press   <= accept_c[NUM_BTN-1:0] & s2[NUM_BTN-1:0];
            btn_release <= accept_c[NUM_BTN-1:0] & ~s2[NUM_BTN-1:0];
            sw_change   <= |accept_c[IN_W-1:NUM_BTN];
            for (int i = 0; i < int'(IN_W); i++) begin
                if (s2[i] == stable[i] || accept_c[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Heartbeat: hb toggles each time the half-period counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    // Zero-extend first so truncation to the LED width is a plain slice.
    always_comb begin
        btn_ext_c = EXT_W'(btn_state);
        sw_ext_c  = EXT_W'(sw_state);
        led_c     = '0;
        case (led_mode)
            MODE_OFF:  led_c = '0;
            MODE_HOST: led_c = led_host;
            MODE_SW:   led_c = sw_ext_c[LED_W-1:0];
            MODE_STAT: led_c = {btn_ext_c[LED_W-2:0], hb};
            default:   led_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= '0;
        end else begin
            led_out <= led_c;
        end
    end

endmodule

// File: doc/board_gpio_ctrl.md
Name: board_gpio_ctrl

Overview:
Parametrised board GPIO front-end placed in the board top level, beside the fpga core instance.
- Takes raw buttons and switches, synchronises and debounces them, and produces stable levels plus single-cycle press, release and change pulses.
- Drives the board LEDs from a selectable source: off, host-written value, switch mirror, or heartbeat plus button status.
- Replaces the hard-wired LED tie-off and unused GPIO inputs in current board tops.

Parameters:
NUM_BTN, 5, number of push-buttons (>=1)
SW_W, 8, switch bank width (>=1)
LED_W, 8, LED bank width (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive mismatching samples required to accept a new input level (>=1)
HB_HALF_PERIOD, 50000000, clk cycles per heartbeat half-period (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
btn_in  input  NUM_BTN  raw asynchronous button inputs
sw_in  input  SW_W  raw asynchronous switch inputs
btn_state  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse per bit on debounced 0->1
btn_release  output  NUM_BTN  one-cycle pulse per bit on debounced 1->0
sw_state  output  SW_W  debounced switch levels
sw_change  output  1  one-cycle pulse when any sw_state bit changes
led_mode  input  2  LED source: 0 off, 1 host, 2 switch mirror, 3 status
led_host  input  LED_W  host-supplied LED value (mode 1)
led_out  output  LED_W  registered LED drive

Behaviour:
Reset:
- On rst=1 at a clock edge, clear every output, sync flop, stable register, debounce counter, heartbeat counter and heartbeat bit to 0.
- rst mid-debounce discards the partial count.
- An input already high at reset release is accepted after the normal debounce, and produces a press pulse.

Synchroniser:
- Every btn_in/sw_in bit passes through 2 flops. The synchronised value s2 reflects an input change 2 edges after it is set up.

Debounce (independent per bit):
- Counter width is clog2(DEBOUNCE_CYCLES+1).
- If s2 == stable, counter <= 0.
- If s2 != stable and counter < DEBOUNCE_CYCLES-1, counter <= counter+1.
- If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
- Any single cycle of s2 == stable during the count restarts it, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Total latency from a clean raw edge to the stable change: DEBOUNCE_CYCLES+2 cycles.
- With DEBOUNCE_CYCLES=1, a new level is accepted on the first mismatching sample.

Pulses:
- btn_press, btn_release and sw_change are registered on the same edge that updates stable. Each pulse is high for exactly the first cycle the new level is visible on btn_state/sw_state.
- Several bits may pulse in the same cycle.
- sw_change is the OR of all per-bit switch updates.
- Outside such cycles all pulse outputs are 0.

Heartbeat:
- Free-running counter 0..HB_HALF_PERIOD-1 that wraps to 0.
- The hb bit toggles on each wrap, giving a period of 2*HB_HALF_PERIOD cycles.

LED mux (registered; led_mode/led_host changes appear on led_out 1 cycle later):
- mode 0: all zeros.
- mode 1: led_host.
- mode 2: sw_state, zero-extended or truncated (LSB-aligned) to LED_W.
- mode 3: led_out[0] = hb; led_out[LED_W-1:1] = btn_state, zero-extended or truncated (LSB-aligned) to LED_W-1.

Other rules:
- No handshake exists.
- Outputs are valid every cycle after reset.
- Pulses have no backpressure and must be consumed in the cycle they are asserted.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HB_HALF_PERIOD=8, NUM_BTN=5, SW_W=8, LED_W=8.

1. Reset: hold btn_in=5'h1F, rst=1 for 3 cycles, then rst=0 -> all outputs 0 during reset; btn_state=5'h1F exactly 6 cycles after release; btn_press=5'h1F for exactly that one cycle.
2. Glitch reject: btn_in[2] high for 3 cycles, then low -> btn_state stays 0; no btn_press. Then high for 6 cycles -> btn_state[2]=1 exactly 6 cycles after the rising edge, with a 1-cycle btn_press[2].
3. Release and simultaneity: drop btn_in[0] and btn_in[4] on the same edge -> btn_release=5'h11 for one cycle; btn_state returns to 0.
4. Switches: sw_in 8'h00->8'hA5 -> sw_state=8'hA5 after 6 cycles; single-cycle sw_change=1. A bouncy sw_in[0] (toggles every 2 cycles for 10 cycles) -> no sw_change.
5. LED modes: led_mode=1, led_host=8'h3C -> led_out=8'h3C next cycle. mode 2 -> led_out=8'hA5. mode 0 -> 8'h00. mode 3 with btn_state=5'h05 -> led_out[7:1]=7'h05 and led_out[0] toggling every 8 cycles (period 16).
6. Mid-operation reset: assert rst while btn_in[1] has been high for 3 cycles -> btn_state stays 0; after release, the full 6-cycle debounce is required before btn_state[1]=1.
